// File: rtl/if_id_queue.sv
// IF->ID instruction queue: buffers {pc4, instruction} pairs from fetch and
// hands them to decode in order. Optional performance counters under IFQ_PERF_EN.
module if_id_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IFQ_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flushed_entries,
`endif
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc4_in,
    input  logic        fetch_valid,
    output logic        hazard,
    input  logic        outBranchControl,
    input  logic        jump,
    output logic [31:0] instruction_out,
    output logic [31:0] pc4_out,
    output logic        id_valid,
    input  logic        id_ready
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      head;
    logic             full;
    logic             not_empty;
    logic             flush;
    logic             push;
    logic             pop;

    // Handshakes: an entry moves on a rising edge only when its producer's
    // valid and the consumer's ready (fetch side: ~hazard) are both high and
    // no redirect is flushing; ready never depends combinationally on valid.
    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);
    assign flush     = outBranchControl | jump;
    assign push      = fetch_valid & ~full & ~flush;
    assign pop       = not_empty & id_ready & ~flush;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {pc4_in, instruction_in};
    end

    // Storage holds no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign hazard          = full;
    assign id_valid        = not_empty;
    assign instruction_out = not_empty ? head[31:0]  : NOP_INST;
    assign pc4_out         = not_empty ? head[63:32] : 32'h0;

`ifdef IFQ_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flushed_entries_q, flushed_entries_d;
    logic [32:0] flushed_sum;

    assign flushed_sum = {1'b0, flushed_entries_q} + 33'(count_q) + 33'(fetch_valid);

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        flushed_entries_d = flushed_entries_q;
        if (fetch_valid && full && !flush && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (flush)
            flushed_entries_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            flushed_entries_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            flushed_entries_q <= flushed_entries_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign flushed_entries = flushed_entries_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: drivers push expected entries into exp_q,
// a negedge monitor pops and compares every entry the queue hands to decode.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [31:0] pc4_in;
    logic        fetch_valid;
    logic        hazard;
    logic        outBranchControl;
    logic        jump;
    logic [31:0] instruction_out;
    logic [31:0] pc4_out;
    logic        id_valid;
    logic        id_ready;
`ifdef IFQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flushed_entries;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(2), .NOP_INST(32'h00000013)) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef IFQ_PERF_EN
        .stall_cycles     (stall_cycles),
        .flushed_entries  (flushed_entries),
`endif
        .instruction_in   (instruction_in),
        .pc4_in           (pc4_in),
        .fetch_valid      (fetch_valid),
        .hazard           (hazard),
        .outBranchControl (outBranchControl),
        .jump             (jump),
        .instruction_out  (instruction_out),
        .pc4_out          (pc4_out),
        .id_valid         (id_valid),
        .id_ready         (id_ready)
    );

    // ---------------- check helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_empty(input string name);
        check32({name, "_id_valid"}, {31'd0, id_valid}, 32'd0);
        check32({name, "_hazard"},   {31'd0, hazard},   32'd0);
        check32({name, "_inst"},     instruction_out,   NOP);
        check32({name, "_pc4"},      pc4_out,           32'd0);
    endtask

    task automatic check_head(input string name, input logic [31:0] inst, input logic [31:0] pc4);
        check32({name, "_id_valid"}, {31'd0, id_valid}, 32'd1);
        check32({name, "_inst"},     instruction_out,   inst);
        check32({name, "_pc4"},      pc4_out,           pc4);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] inst, input logic [31:0] pc4,
                         input logic rdy);
        fetch_valid    = fv;
        instruction_in = inst;
        pc4_in         = pc4;
        id_ready       = rdy;
    endtask

    // Fetch that the bench knows will be accepted on the next edge.
    task automatic fetch_ok(input logic [31:0] inst, input logic [31:0] pc4, input logic rdy);
        drive(1'b1, inst, pc4, rdy);
        exp_q.push_back({pc4, inst});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1 &&
            outBranchControl === 1'b0 && jump === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %h expected nothing", {pc4_out, instruction_out});
            end else begin
                mon_exp = exp_q.pop_front();
                check32("pop_inst", instruction_out, mon_exp[31:0]);
                check32("pop_pc4",  pc4_out,         mon_exp[63:32]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; outBranchControl = 1'b0; jump = 1'b0;
        drive(1'b1, 32'h00500093, 32'h4, 1'b0);

        // 1. reset held two cycles with fetch_valid high
        cycle();
        check_empty("reset1");
        cycle();
        check_empty("reset2");
        reset = 1'b0;

        // 2. fill to full, third fetch is refused
        fetch_ok(32'h00500093, 32'h4, 1'b0);
        cycle();
        check32("fill1_hazard", {31'd0, hazard}, 32'd0);
        check_head("fill1", 32'h00500093, 32'h4);
        fetch_ok(32'h00A00113, 32'h8, 1'b0);
        cycle();
        check32("fill2_hazard", {31'd0, hazard}, 32'd1);
        drive(1'b1, 32'h00208233, 32'hC, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check32("full_hold_hazard", {31'd0, hazard}, 32'd1);
            check_head("full_hold", 32'h00500093, 32'h4);
        end

        // 3. full + pop: pop happens, push refused until the next edge
        drive(1'b1, 32'h00208233, 32'hC, 1'b1);
        cycle();
        check32("fullpop_hazard", {31'd0, hazard}, 32'd0);
        check_head("fullpop", 32'h00A00113, 32'h8);
        exp_q.push_back({32'hC, 32'h00208233});
        cycle();
        check32("fullpop2_hazard", {31'd0, hazard}, 32'd0);
        check_head("fullpop2", 32'h00208233, 32'hC);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();
        check_empty("drained");

        // 4. steady stream, count stays at one
        for (int i = 0; i < 10; i++) begin
            fetch_ok(32'h10000013 + 32'(i), 32'h4 * 32'(i + 1), 1'b1);
            cycle();
            check32("stream_valid",  {31'd0, id_valid}, 32'd1);
            check32("stream_hazard", {31'd0, hazard},   32'd0);
            check32("stream_pc4",    pc4_out,           32'h4 * 32'(i + 1));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();
        check_empty("stream_end");

        // 5. flush via jump, then via outBranchControl
        for (int k = 0; k < 2; k++) begin
            fetch_ok(32'h00100093, 32'hF0, 1'b0);
            cycle();
            fetch_ok(32'h00200113, 32'hF4, 1'b0);
            cycle();
            check32("pre_flush_hazard", {31'd0, hazard}, 32'd1);
            drive(1'b1, 32'h00300193, 32'hF8, 1'b1);
            if (k == 0) jump = 1'b1; else outBranchControl = 1'b1;
            exp_q.delete();
            cycle();
            check_empty("flushed");
            jump = 1'b0; outBranchControl = 1'b0;
            fetch_ok(32'h00C00193, 32'h104, 1'b0);
            cycle();
            check_head("after_flush", 32'h00C00193, 32'h104);
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            cycle();
            check_empty("after_flush_drain");
        end

        // 6. reset mid-operation with a simultaneous flush and fetch
        fetch_ok(32'h00400213, 32'h200, 1'b0);
        cycle();
        check_head("pre_reset", 32'h00400213, 32'h200);
        reset = 1'b1; jump = 1'b1; drive(1'b1, 32'h00500293, 32'h204, 1'b1);
        exp_q.delete();
        cycle();
        check_empty("mid_reset");
        reset = 1'b0; jump = 1'b0;

        // perf: three blocked cycles, then flush of two entries plus a fetch
        fetch_ok(32'h00600313, 32'h300, 1'b0);
        cycle();
        fetch_ok(32'h00700393, 32'h304, 1'b0);
        cycle();
        drive(1'b1, 32'h00800413, 32'h308, 1'b0);
        repeat (3) cycle();
        check_head("blocked", 32'h00600313, 32'h300);
        jump = 1'b1;
        exp_q.delete();
        cycle();
        jump = 1'b0;
        check_empty("perf_flush");
`ifdef IFQ_PERF_EN
        check32("stall_cycles",    stall_cycles,    32'd3);
        check32("flushed_entries", flushed_entries, 32'd3);
`endif
        reset = 1'b1; outBranchControl = 1'b1;
        cycle();
        check_empty("final_reset");
`ifdef IFQ_PERF_EN
        check32("stall_cycles_rst",    stall_cycles,    32'd0);
        check32("flushed_entries_rst", flushed_entries, 32'd0);
`endif
        reset = 1'b0; outBranchControl = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        check_empty("idle");

        // ---------------- final report ----------------
        check32("exp_q_leftover", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
